pipelined_tree_multiplier: RTL and testbench

Parametrised, pipelined integer multiplier that succeeds the fixed 8x8 combinational tree multiplier in the CPU datapath. It accepts WIDTH-bit operands in unsigned or two's-complement signed mode and produces a full 2*WIDTH-bit product after a fixed, parametrised number of register stages. It adds valid/ready flow control with backpressure and an overflow flag for ALU consumers that keep only the low half. It sits between the ALU operand latches and the writeback mux.

---
 rtl/pipelined_tree_multiplier.sv | 157 +++++++++++++++
 tb/tb_pipelined_tree_multiplier.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_tree_multiplier.sv
// pipelined_tree_multiplier: WIDTH x WIDTH Baugh-Wooley carry-save multiplier, STAGES-deep, valid/ready with a global stall
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid, in_ready     input handshake (in_ready = pipeline can advance, forced low in reset)
//   a, b, signed_mode      operands and per-beat mode (1 = two's complement)
//   out_valid, out_ready   output handshake
//   product, overflow      2*WIDTH-bit product; overflow = result does not fit in WIDTH bits
module pipelined_tree_multiplier #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);
    localparam int W2 = 2 * WIDTH;
    localparam int N  = WIDTH - 1;
    localparam int M  = STAGES - 1;

    // Row j of the partial-product array; row WIDTH holds the Baugh-Wooley correction (2^W + 2^(2W-1)).
    function automatic logic [W2-1:0] pp_row(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic m, input int j);
        pp_row = '0;
        if (j == WIDTH) begin
            pp_row[WIDTH] = m;
            pp_row[W2-1]  = m;
        end else
            for (int i = 0; i < WIDTH; i++)
                pp_row[i + j] = (x[i] & y[j]) ^ (m & ((i == WIDTH - 1) != (j == WIDTH - 1)));
    endfunction

    // Full-adder rows folding partial-product rows 2+lo .. 2+hi-1 into the sum/carry pair; returns {sum, carry}.
    function automatic logic [2*W2-1:0] csa_span(input logic [W2-1:0] s_i, input logic [W2-1:0] c_i,
                                                 input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic m, input int lo, input int hi);
        logic [W2-1:0] s, c, r;
        s = s_i;
        c = c_i;
        for (int t = 0; t < N; t++)
            if (t >= lo && t < hi) begin
                r = pp_row(x, y, m, t + 2);
                {s, c} = {s ^ c ^ r, ((s & c) | (s & r) | (c & r)) << 1};
            end
        csa_span = {s, c};
    endfunction

    logic              w_adv, w_acc, w_lv, w_lm;
    logic [W2-1:0]     w_s0, w_c0, w_sum;
    logic [2*W2-1:0]   w_lsc;
    logic              r_pv, r_pm;
    logic [W2-1:0]     r_p;

    assign w_adv    = !r_pv || out_ready;
    assign in_ready = !rst && w_adv;
    assign w_acc    = in_valid && in_ready;
    assign w_s0     = pp_row(a, b, signed_mode, 0);
    assign w_c0     = pp_row(a, b, signed_mode, 1);

    generate
        if (STAGES == 1) begin : g_one
            assign w_lv  = w_acc;
            assign w_lm  = signed_mode;
            assign w_lsc = csa_span(w_s0, w_c0, a, b, signed_mode, 0, N);
        end else begin : g_multi
            logic              r_v [M], r_m [M];
            logic [W2-1:0]     r_s [M], r_c [M];
            logic              w_v [M], w_m [M];
            logic [W2-1:0]     w_s [M], w_c [M];
            logic [WIDTH-1:0]  w_a [M], w_b [M];
            logic [2*W2-1:0]   w_sc [M];
            // Operands ride along only as far as the last segment that still has rows to generate.
            if (M > 1) begin : g_ops
                logic [WIDTH-1:0] r_a [M-1], r_b [M-1];
                always_ff @(posedge clk)
                    if (rst)
                        for (int k = 0; k < M - 1; k++) begin
                            r_a[k] <= '0;
                            r_b[k] <= '0;
                        end
                    else if (w_adv)
                        for (int k = 0; k < M - 1; k++) begin
                            r_a[k] <= w_a[k];
                            r_b[k] <= w_b[k];
                        end
                always_comb begin
                    w_a[0] = a;
                    w_b[0] = b;
                    for (int k = 1; k < M; k++) begin
                        w_a[k] = r_a[k-1];
                        w_b[k] = r_b[k-1];
                    end
                end
            end else begin : g_ops
                always_comb begin
                    w_a[0] = a;
                    w_b[0] = b;
                end
            end
            always_comb begin
                w_v[0] = w_acc;
                w_m[0] = signed_mode;
                w_s[0] = w_s0;
                w_c[0] = w_c0;
                for (int k = 1; k < M; k++) begin
                    w_v[k] = r_v[k-1];
                    w_m[k] = r_m[k-1];
                    w_s[k] = r_s[k-1];
                    w_c[k] = r_c[k-1];
                end
                for (int k = 0; k < M; k++)
                    w_sc[k] = csa_span(w_s[k], w_c[k], w_a[k], w_b[k], w_m[k], k * N / M, (k + 1) * N / M);
            end
            always_ff @(posedge clk)
                if (rst)
                    for (int k = 0; k < M; k++) begin
                        r_v[k] <= 1'b0;
                        r_m[k] <= 1'b0;
                        r_s[k] <= '0;
                        r_c[k] <= '0;
                    end
                else if (w_adv)
                    for (int k = 0; k < M; k++) begin
                        r_v[k]           <= w_v[k];
                        r_m[k]           <= w_m[k];
                        {r_s[k], r_c[k]} <= w_sc[k];
                    end
            assign w_lv  = r_v[M-1];
            assign w_lm  = r_m[M-1];
            assign w_lsc = {r_s[M-1], r_c[M-1]};
        end
    endgenerate

    assign w_sum = w_lsc[2*W2-1:W2] + w_lsc[W2-1:0];

    always_ff @(posedge clk)
        if (rst) begin
            r_pv <= 1'b0;
            r_pm <= 1'b0;
            r_p  <= '0;
        end else if (w_adv) begin
            r_pv <= w_lv;
            r_pm <= w_lm;
            r_p  <= w_sum;
        end

    assign out_valid = r_pv;
    assign product   = r_p;
    assign overflow  = r_pm ? ~(&r_p[W2-1:WIDTH-1] | ~|r_p[W2-1:WIDTH-1]) : |r_p[W2-1:WIDTH];
endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// tb_pipelined_tree_multiplier: six multiplier configurations (W=4 S=1..4, W=8 S=2, W=8 S=3) against an arithmetic scoreboard
module tb_pipelined_tree_multiplier;
    typedef struct {
        logic [15:0] p;
        logic        o;
        int          n;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mon_en = 1'b0;
    logic       iv [6], md [6], ordy [6];
    logic [7:0] a_d [6], b_d [6];
    wire        ir_o [6], ov_o [6], ovf_o [6];
    wire [15:0] p_o [6];
    int         n_ret [6];
    int         n_tests = 0, n_fail = 0;
    logic [15:0] cp [8];
    logic        co [8];
    int          nc;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 6; g++) begin : g_cfg
        localparam int W = (g < 4) ? 4 : 8;
        localparam int S = (g < 4) ? g + 1 : g - 2;
        logic [2*W-1:0] p;
        logic           ov, ovf, ir;
        ent_t           q [$];

        pipelined_tree_multiplier #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir),
            .a(a_d[g][W-1:0]), .b(b_d[g][W-1:0]), .signed_mode(md[g]),
            .out_valid(ov), .out_ready(ordy[g]), .product(p), .overflow(ovf));

        assign ir_o[g]  = ir;
        assign ov_o[g]  = ov;
        assign ovf_o[g] = ovf;
        assign p_o[g]   = 16'(p);

        // Each entry counts the advancing edges it has seen; it is at the output after S of them.
        always @(negedge clk) if (mon_en) begin
            logic ev, adv;
            logic [W-1:0] x, y;
            longint pa, pb, pr;
            ev = q.size() != 0 && q[0].n == S;
            check($sformatf("c%0d out_valid", g), 64'(ov), 64'(ev));
            if (ev && ov) begin
                check($sformatf("c%0d product", g), 64'(p), 64'(q[0].p));
                check($sformatf("c%0d overflow", g), 64'(ovf), 64'(q[0].o));
            end
            adv = !ev || ordy[g];
            check($sformatf("c%0d in_ready", g), 64'(ir), 64'(!rst && adv));
            if (rst)
                q.delete();
            else if (adv) begin
                if (ev)
                    void'(q.pop_front());
                foreach (q[k])
                    q[k].n++;
                if (iv[g]) begin
                    x  = a_d[g][W-1:0];
                    y  = b_d[g][W-1:0];
                    pa = md[g] ? longint'($signed(x)) : longint'(x);
                    pb = md[g] ? longint'($signed(y)) : longint'(y);
                    pr = pa * pb;
                    q.push_back('{16'(pr[2*W-1:0]),
                                  md[g] ? (pr < -(longint'(1) << (W - 1)) || pr >= (longint'(1) << (W - 1)))
                                        : (pr >= (longint'(1) << W)),
                                  1});
                end
            end
        end
    end

    always @(negedge clk)
        if (mon_en && !rst)
            for (int i = 0; i < 6; i++)
                if (ov_o[i] && ordy[i])
                    n_ret[i]++;

    task automatic send(input int g, input logic [7:0] x, input logic [7:0] y, input logic m);
        int   t = 0;
        logic acc;
        iv[g] = 1'b1; a_d[g] = x; b_d[g] = y; md[g] = m;
        do begin
            @(negedge clk);
            acc = ir_o[g];
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        iv[g] = 1'b0;
        check("send accepted", 64'(acc), 64'(1));
    endtask

    task automatic expect_out(input int g, input logic [15:0] ep, input logic eo, input int lat);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ov_o[g] && t < 20);
        check("latency", 64'(t), 64'(lat));
        check("directed product", 64'(p_o[g]), 64'(ep));
        check("directed overflow", 64'(ovf_o[g]), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int g, input int cycles);
        nc = 0;
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            if (ov_o[g] && ordy[g] && nc < 8) begin
                cp[nc] = p_o[g];
                co[nc] = ovf_o[g];
                nc++;
            end
        end
    endtask

    task automatic run_rand(input int g, input int n);
        logic done = 1'b0;
        int   r0 = n_ret[g];
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    if (g < 4)
                        send(g, {4'd0, i[3:0]}, {4'd0, i[7:4]}, i[8]);
                    else
                        send(g, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ordy[g] = $urandom_range(0, 3) != 0;
                end
                ordy[g] = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check($sformatf("c%0d retired count", g), 64'(n_ret[g] - r0), 64'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 6; i++) begin
            iv[i] = 1'b0; md[i] = 1'b0; ordy[i] = 1'b1; a_d[i] = '0; b_d[i] = '0; n_ret[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("reset out_valid", 64'(ov_o[i]), 64'(0));
            check("reset product", 64'(p_o[i]), 64'(0));
            check("reset overflow", 64'(ovf_o[i]), 64'(0));
            check("reset in_ready", 64'(ir_o[i]), 64'(1));
        end
        @(posedge clk);
        #1;

        send(4, 8'hFF, 8'hFF, 1'b0); expect_out(4, 16'hFE01, 1'b1, 2);
        send(4, 8'h0F, 8'h11, 1'b0); expect_out(4, 16'h00FF, 1'b0, 2);
        send(4, 8'h80, 8'h80, 1'b1); expect_out(4, 16'h4000, 1'b1, 2);
        send(4, 8'hFF, 8'h05, 1'b1); expect_out(4, 16'hFFFB, 1'b0, 2);
        send(4, 8'h7F, 8'h80, 1'b1); expect_out(4, 16'hC080, 1'b1, 2);

        fork
            begin
                send(4, 8'd2, 8'd3, 1'b0);
                send(4, 8'd4, 8'd5, 1'b0);
                send(4, 8'd6, 8'd7, 1'b0);
            end
            collect(4, 30);
            begin
                int t = 0;
                do begin
                    @(posedge clk);
                    #1;
                    t++;
                end while (!ov_o[4] && t < 20);
                ordy[4] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall in_ready", 64'(ir_o[4]), 64'(0));
                    check("stall hold product", 64'(p_o[4]), 64'(6));
                end
                @(posedge clk);
                #1;
                ordy[4] = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        check("stall beat count", 64'(nc), 64'(3));
        check("stall order 0", 64'(cp[0]), 64'(6));
        check("stall order 1", 64'(cp[1]), 64'(20));
        check("stall order 2", 64'(cp[2]), 64'(42));

        fork
            for (int i = 0; i < 4; i++)
                send(5, 8'hFF, 8'hFF, i[0]);
            collect(5, 20);
        join
        @(posedge clk);
        #1;
        check("mode beat count", 64'(nc), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("mode product", 64'(cp[i]), i[0] ? 64'h0001 : 64'hFE01);
            check("mode overflow", 64'(co[i]), i[0] ? 64'(0) : 64'(1));
        end

        send(5, 8'd1, 8'd1, 1'b0);
        send(5, 8'd2, 8'd2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("flush out_valid", 64'(ov_o[5]), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("flush out_valid", 64'(ov_o[5]), 64'(0));
        end
        @(posedge clk);
        #1;
        send(5, 8'd3, 8'd3, 1'b0); expect_out(5, 16'd9, 1'b0, 3);

        for (int g = 0; g < 4; g++)
            run_rand(g, 512);
        run_rand(4, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
